// File: rtl/wb_fir_engine_if.sv
// Wishbone slave bundle used by the FIR engine.
// Signal names follow the Caravel wbs_* port set.
interface wb_fir_engine_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wb_fir_engine.sv
// Wishbone-attached FIR accelerator: register-file taps, circular sample history,
// single sequential MAC, output FIFO with backpressure and a done interrupt.
module wb_fir_engine #(
   parameter int          DW          = 32,
   parameter int          NTAPS       = 11,
   parameter int          OFIFO_DEPTH = 4,
   parameter logic [31:0] BASE_ADDR   = 32'h3200_0000
) (
   input  logic           wb_clk_i,
   input  logic           wb_rst_i,
   wb_fir_engine_if.slave wb,
   output logic           irq
);
   localparam int IW = $clog2(NTAPS);
   localparam int AW = 2 * DW + $clog2(NTAPS);
   localparam int FW = $clog2(OFIFO_DEPTH);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NTAPS - 1);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   localparam logic [FW-1:0] PTR_ONE   = FW'(1);
   localparam logic [FW:0]   CNT_ONE   = {{FW{1'b0}}, 1'b1};
   localparam logic [FW:0]   FIFO_FULL = OFIFO_DEPTH[FW:0];
   localparam logic [11:0]   TAP_END   = 12'(64 + 4 * NTAPS);
   localparam logic signed [AW-1:0] RES_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] RES_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLR    = 3'd1,
      ST_WAIT_X = 3'd2,
      ST_MAC    = 3'd3,
      ST_PUSH   = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   function automatic logic [31:0] ext_word(input logic signed [DW-1:0] v);
      ext_word = 32'(v);
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] sel);
      logic [31:0] m;
      m = old_w;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) begin
            m[8*b +: 8] = new_w[8*b +: 8];
         end else begin
            m[8*b +: 8] = old_w[8*b +: 8];
         end
      end
      merge_bytes = m;
   endfunction

   state_t                state_r;
   logic signed [DW-1:0]  taps_r [NTAPS];
   logic signed [DW-1:0]  hist_r [NTAPS];
   logic [IW-1:0]         cur_r;
   logic [IW-1:0]         idx_r;
   logic [IW-1:0]         cnt_r;
   logic signed [AW-1:0]  acc_r;
   logic [31:0]           len_r;
   logic [31:0]           out_cnt_r;
   logic [4:0]            shift_r;
   logic                  sat_r;
   logic                  done_r;
   logic                  ack_r;
   logic [31:0]           dat_o_r;
   logic signed [DW-1:0]  fifo_r [OFIFO_DEPTH];
   logic [FW-1:0]         wp_r;
   logic [FW-1:0]         rp_r;
   logic [FW:0]           fcnt_r;

   logic [11:0]           off_s;
   logic                  hit_s, req_s, idle_s, x_ready_s, stall_s, acc_req_s;
   logic                  wr_s, rd_s, is_x_s, is_y_s, is_tap_s, is_ctrl_s;
   logic [IW-1:0]         tap_idx_s;
   logic                  fifo_empty_s, fifo_full_s, push_s, pop_s, x_take_s, start_s;
   logic [IW-1:0]         nxt_cur_s;
   logic [31:0]           tap_new_s, len_new_s, cfg_new_s, cfg_rd_s, rd_data_s;
   logic [2*DW-1:0]       prod_s;
   logic signed [AW-1:0]  prod_ext_s, shifted_s;
   logic signed [DW-1:0]  res_s;
   logic [31:0]           out_cnt_inc_s;

   // Address decode, request qualification and handshake-derived strobes.
   always_comb begin
      off_s        = wb.wbs_adr_i[11:0];
      hit_s        = (wb.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
      req_s        = wb.wbs_stb_i & wb.wbs_cyc_i & hit_s & ~ack_r;
      idle_s       = (state_r == ST_IDLE) || (state_r == ST_DONE);
      x_ready_s    = (state_r == ST_WAIT_X);
      is_ctrl_s    = (off_s == 12'h000);
      is_x_s       = (off_s == 12'h080);
      is_y_s       = (off_s == 12'h084);
      is_tap_s     = (off_s >= 12'h040) && (off_s < TAP_END) && ~is_x_s && ~is_y_s;
      tap_idx_s    = IW'(off_s[11:2] - 10'h010);
      // X writes hold the bus off only while a run is in progress but cannot take a sample yet.
      stall_s      = wb.wbs_we_i & is_x_s & ~idle_s & ~x_ready_s;
      acc_req_s    = req_s & ~stall_s;
      wr_s         = acc_req_s & wb.wbs_we_i;
      rd_s         = acc_req_s & ~wb.wbs_we_i;
      fifo_empty_s = (fcnt_r == {(FW+1){1'b0}});
      fifo_full_s  = (fcnt_r == FIFO_FULL);
      push_s       = (state_r == ST_PUSH) & ~fifo_full_s;
      pop_s        = rd_s & is_y_s & ~fifo_empty_s;
      x_take_s     = wr_s & is_x_s & x_ready_s;
      start_s      = wr_s & is_ctrl_s & wb.wbs_dat_i[0] & (state_r == ST_IDLE);
      nxt_cur_s    = (cur_r == LAST_IDX) ? {IW{1'b0}} : cur_r + IDX_ONE;
      cfg_rd_s     = {23'd0, sat_r, 3'd0, shift_r};
      tap_new_s    = merge_bytes(ext_word(taps_r[tap_idx_s]), wb.wbs_dat_i, wb.wbs_sel_i);
      len_new_s    = merge_bytes(len_r, wb.wbs_dat_i, wb.wbs_sel_i);
      cfg_new_s    = merge_bytes(cfg_rd_s, wb.wbs_dat_i, wb.wbs_sel_i);
      out_cnt_inc_s = out_cnt_r + 32'd1;
   end

   // MAC product, output scaling and optional saturation.
   always_comb begin
      prod_s     = {{DW{taps_r[cnt_r][DW-1]}}, taps_r[cnt_r]} *
                   {{DW{hist_r[idx_r][DW-1]}}, hist_r[idx_r]};
      prod_ext_s = {{(AW-2*DW){prod_s[2*DW-1]}}, prod_s};
      shifted_s  = acc_r >>> shift_r;
      if (sat_r && (shifted_s > RES_MAX)) begin
         res_s = RES_MAX[DW-1:0];
      end else if (sat_r && (shifted_s < RES_MIN)) begin
         res_s = RES_MIN[DW-1:0];
      end else begin
         res_s = shifted_s[DW-1:0];
      end
   end

   // Read-data multiplexer for the register map.
   always_comb begin
      rd_data_s = 32'h0000_0000;
      if (is_ctrl_s) begin
         rd_data_s = {26'd0, ~fifo_empty_s, x_ready_s, 1'b0, idle_s, done_r, 1'b0};
      end else if (off_s == 12'h004) begin
         rd_data_s = len_r;
      end else if (off_s == 12'h008) begin
         rd_data_s = out_cnt_r;
      end else if (off_s == 12'h00C) begin
         rd_data_s = cfg_rd_s;
      end else if (is_tap_s) begin
         rd_data_s = ext_word(taps_r[tap_idx_s]);
      end else if (is_y_s && !fifo_empty_s) begin
         rd_data_s = ext_word(fifo_r[rp_r]);
      end else begin
         rd_data_s = 32'h0000_0000;
      end
   end

   // Single-cycle registered acknowledge and read data.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_r   <= 1'b0;
         dat_o_r <= 32'h0000_0000;
      end else begin
         ack_r   <= acc_req_s;
         dat_o_r <= rd_s ? rd_data_s : 32'h0000_0000;
      end
   end

   // Configuration registers and taps; writable only while idle.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         len_r   <= 32'd0;
         shift_r <= 5'd0;
         sat_r   <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            taps_r[i] <= '0;
         end
      end else if (wr_s && idle_s) begin
         if (off_s == 12'h004) begin
            len_r <= len_new_s;
         end else if (off_s == 12'h00C) begin
            shift_r <= cfg_new_s[4:0];
            sat_r   <= cfg_new_s[8];
         end else if (is_tap_s) begin
            taps_r[tap_idx_s] <= tap_new_s[DW-1:0];
         end else begin
            len_r <= len_r;
         end
      end else begin
         len_r <= len_r;
      end
   end

   // Control FSM with history buffer and accumulator.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_r   <= ST_IDLE;
         cur_r     <= LAST_IDX;
         idx_r     <= {IW{1'b0}};
         cnt_r     <= {IW{1'b0}};
         acc_r     <= '0;
         out_cnt_r <= 32'd0;
         done_r    <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            hist_r[i] <= '0;
         end
      end else begin
         if (rd_s && is_ctrl_s) begin
            done_r <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  out_cnt_r <= 32'd0;
                  cnt_r     <= {IW{1'b0}};
                  state_r   <= (len_r == 32'd0) ? ST_DONE : ST_CLR;
               end
            end
            ST_CLR: begin
               hist_r[cnt_r] <= '0;
               cnt_r         <= cnt_r + IDX_ONE;
               if (cnt_r == LAST_IDX) begin
                  cur_r   <= LAST_IDX;
                  state_r <= ST_WAIT_X;
               end
            end
            ST_WAIT_X: begin
               if (x_take_s) begin
                  hist_r[nxt_cur_s] <= wb.wbs_dat_i[DW-1:0];
                  cur_r             <= nxt_cur_s;
                  idx_r             <= nxt_cur_s;
                  cnt_r             <= {IW{1'b0}};
                  acc_r             <= '0;
                  state_r           <= ST_MAC;
               end
            end
            ST_MAC: begin
               // idx_r walks backwards from the newest sample, wrapping around the ring.
               acc_r <= acc_r + prod_ext_s;
               idx_r <= (idx_r == {IW{1'b0}}) ? LAST_IDX : idx_r - IDX_ONE;
               cnt_r <= cnt_r + IDX_ONE;
               if (cnt_r == LAST_IDX) begin
                  state_r <= ST_PUSH;
               end
            end
            ST_PUSH: begin
               if (!fifo_full_s) begin
                  out_cnt_r <= out_cnt_inc_s;
                  state_r   <= (out_cnt_inc_s == len_r) ? ST_DONE : ST_WAIT_X;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b1;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Output FIFO; contents persist across runs and clear only on reset.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wp_r   <= {FW{1'b0}};
         rp_r   <= {FW{1'b0}};
         fcnt_r <= {(FW+1){1'b0}};
         for (int i = 0; i < OFIFO_DEPTH; i++) begin
            fifo_r[i] <= '0;
         end
      end else begin
         if (push_s) begin
            fifo_r[wp_r] <= res_s;
            wp_r         <= wp_r + PTR_ONE;
         end
         if (pop_s) begin
            rp_r <= rp_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   fcnt_r <= fcnt_r + CNT_ONE;
            2'b01:   fcnt_r <= fcnt_r - CNT_ONE;
            default: fcnt_r <= fcnt_r;
         endcase
      end
   end

   assign wb.wbs_ack_o = ack_r;
   assign wb.wbs_dat_o = dat_o_r;
   assign irq          = done_r;
endmodule

// File: tb/tb_wb_fir_engine.sv
// Directed self-checking bench for wb_fir_engine with hand-computed expectations.
module tb_wb_fir_engine;
   localparam logic [31:0] BASE = 32'h3200_0000;

   logic clk = 1'b0;
   logic rst;
   logic irq;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   lab_taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

   wb_fir_engine_if bus ();

   wb_fir_engine dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb       (bus),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [11:0] off, input logic [31:0] wdat,
                          input logic [3:0] sel, input int budget,
                          output logic [31:0] rdat, output logic acked);
      @(posedge clk);
      #1;
      bus.wbs_adr_i = BASE | {20'h0, off};
      bus.wbs_dat_i = wdat;
      bus.wbs_sel_i = sel;
      bus.wbs_we_i  = we;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_cyc_i = 1'b1;
      acked = 1'b0;
      rdat  = 32'h0;
      for (int i = 0; i < budget && !acked; i++) begin
         @(posedge clk);
         #1;
         if (bus.wbs_ack_o) begin
            acked = 1'b1;
            rdat  = bus.wbs_dat_o;
         end
      end
      bus.wbs_stb_i = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
   endtask

   task automatic wr_sel(input logic [11:0] off, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] r;
      logic        a;
      wb_xfer(1'b1, off, d, sel, 100, r, a);
      check_eq($sformatf("wr_ack_%03h", off), {31'd0, a}, 32'd1);
   endtask

   task automatic wr(input logic [11:0] off, input logic [31:0] d);
      wr_sel(off, d, 4'hF);
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] off, input logic [31:0] exp);
      logic [31:0] r;
      logic        a;
      wb_xfer(1'b0, off, 32'h0, 4'hF, 100, r, a);
      check_eq({tag, "_ack"}, {31'd0, a}, 32'd1);
      check_eq(tag, r, exp);
   endtask

   task automatic set_taps(input int t0, input int t1, input int t2);
      for (int i = 0; i < 11; i++) begin
         wr(12'(64 + 4 * i), (i == 0) ? t0 : (i == 1) ? t1 : (i == 2) ? t2 : 0);
      end
   endtask

   function automatic logic [31:0] lab_ref(input int n);
      longint s;
      s = 0;
      for (int k = 0; k < 11; k++) begin
         if (n - k >= 0) begin
            s += longint'(lab_taps[k]) * longint'(n - k);
         end
      end
      return s[31:0];
   endfunction

   initial begin
      logic [31:0] r;
      logic        a;
      int          imp_y [5] = '{1, 2, 3, 4, 0};
      int          bp_y [6]  = '{30, 70, 110, 150, 190, 230};

      bus.wbs_stb_i = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_dat_i = 32'h0;
      bus.wbs_adr_i = 32'h0;
      rst = 1'b1;
      #2;
      check_eq("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
      check_eq("rst_dat", bus.wbs_dat_o, 32'd0);
      check_eq("rst_irq", {31'd0, irq}, 32'd0);
      #20;
      rst = 1'b0;
      rd_chk("rst_ctrl", 12'h000, 32'h04);

      // Impulse through the first four taps.
      wr(12'h040, 1); wr(12'h044, 2); wr(12'h048, 3); wr(12'h04C, 4);
      wr(12'h004, 5); wr(12'h00C, 0); wr(12'h000, 1);
      for (int n = 0; n < 5; n++) begin
         wr(12'h080, (n == 0) ? 32'd1 : 32'd0);
         repeat (16) @(posedge clk);
         rd_chk($sformatf("imp_y%0d", n), 12'h084, imp_y[n]);
      end
      #1;
      check_eq("imp_irq", {31'd0, irq}, 32'd1);
      rd_chk("imp_cnt", 12'h008, 32'd5);
      rd_chk("imp_ctrl1", 12'h000, 32'h06);
      rd_chk("imp_ctrl2", 12'h000, 32'h04);
      rd_chk("tap3_rb", 12'h04C, 32'd4);

      // Byte lanes, empty Y read, X while idle, zero-length start.
      wr_sel(12'h054, 32'h1122_3344, 4'b0011);
      rd_chk("tap5_lane", 12'h054, 32'h0000_3344);
      rd_chk("y_empty", 12'h084, 32'd0);
      rd_chk("y_empty_ctrl", 12'h000, 32'h04);
      wr(12'h080, 32'd1234);
      wr(12'h004, 0);
      wr(12'h000, 1);
      @(posedge clk);
      #1;
      check_eq("len0_irq", {31'd0, irq}, 32'd1);
      rd_chk("len0_ctrl", 12'h000, 32'h06);

      // Lab vector against the golden model, with a tap write attempted mid-run.
      for (int i = 0; i < 11; i++) wr(12'(64 + 4 * i), lab_taps[i]);
      wr(12'h004, 64); wr(12'h000, 1);
      for (int n = 0; n < 64; n++) begin
         wr(12'h080, n);
         repeat (16) @(posedge clk);
         rd_chk($sformatf("lab_y%0d", n), 12'h084, lab_ref(n));
         if (n == 10) begin
            wr(12'h050, 32'd999);
            rd_chk("tap_busy", 12'h050, 32'd56);
         end
      end
      rd_chk("lab_cnt", 12'h008, 32'd64);
      rd_chk("lab_ctrl", 12'h000, 32'h06);

      // Backpressure: four results fill the FIFO, fifth holds, sixth X stalls.
      set_taps(3, 1, 0);
      wr(12'h004, 6); wr(12'h000, 1);
      for (int n = 0; n < 5; n++) begin
         wr(12'h080, 10 * (n + 1));
         repeat (16) @(posedge clk);
      end
      rd_chk("bp_ctrl", 12'h000, 32'h20);
      wb_xfer(1'b1, 12'h080, 32'd60, 4'hF, 40, r, a);
      check_eq("bp_stall", {31'd0, a}, 32'd0);
      rd_chk("bp_y0", 12'h084, bp_y[0]);
      wr(12'h080, 32'd60);
      repeat (20) @(posedge clk);
      for (int n = 1; n < 6; n++) rd_chk($sformatf("bp_y%0d", n), 12'h084, bp_y[n]);
      rd_chk("bp_empty", 12'h084, 32'd0);
      rd_chk("bp_cnt", 12'h008, 32'd6);
      rd_chk("bp_done", 12'h000, 32'h06);

      // Shift and saturation.
      set_taps(32'h7FFF_FFFF, 0, 0);
      wr(12'h004, 1);
      wr(12'h00C, 32'h100); wr(12'h000, 1); wr(12'h080, 4);
      repeat (16) @(posedge clk);
      rd_chk("sat_pos", 12'h084, 32'h7FFF_FFFF);
      wr(12'h00C, 32'h000); wr(12'h000, 1); wr(12'h080, 4);
      repeat (16) @(posedge clk);
      rd_chk("trunc", 12'h084, 32'hFFFF_FFFC);
      wr(12'h00C, 32'h002); wr(12'h000, 1); wr(12'h080, 4);
      repeat (16) @(posedge clk);
      rd_chk("shift2", 12'h084, 32'h7FFF_FFFF);
      wr(12'h00C, 32'h100); wr(12'h000, 1); wr(12'h080, 32'hFFFF_FFFC);
      repeat (16) @(posedge clk);
      rd_chk("sat_neg", 12'h084, 32'h8000_0000);
      rd_chk("cfg_rb", 12'h00C, 32'h100);

      // Reset asserted mid-MAC, away from a clock edge.
      wr(12'h004, 3); wr(12'h000, 1); wr(12'h080, 5);
      repeat (3) @(posedge clk);
      #1;
      check_eq("pre_rst_irq", {31'd0, irq}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("mid_rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
      check_eq("mid_rst_dat", bus.wbs_dat_o, 32'd0);
      check_eq("mid_rst_irq", {31'd0, irq}, 32'd0);
      #20;
      rst = 1'b0;
      rd_chk("post_tap0", 12'h040, 32'd0);
      rd_chk("post_ctrl", 12'h000, 32'h04);
      rd_chk("post_cnt", 12'h008, 32'd0);
      wr(12'h040, 2); wr(12'h048, 1); wr(12'h004, 3); wr(12'h000, 1);
      wr(12'h080, 7); repeat (16) @(posedge clk); rd_chk("fresh_y0", 12'h084, 32'd14);
      wr(12'h080, 8); repeat (16) @(posedge clk); rd_chk("fresh_y1", 12'h084, 32'd16);
      wr(12'h080, 9); repeat (16) @(posedge clk); rd_chk("fresh_y2", 12'h084, 32'd25);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
